// File: rtl/pipe_cla_if.sv
// pipe_cla_if: operand/result handshake bundle for the pipelined carry-lookahead adder
interface pipe_cla_if #(parameter int WIDTH = 32);
    logic             in_valid, in_ready, cin, sub;
    logic [WIDTH-1:0] op_a, op_b, sum;
    logic             out_valid, out_ready, cout, ovf, zero;
    modport master (output in_valid, op_a, op_b, cin, sub, out_ready,
                    input in_ready, out_valid, sum, cout, ovf, zero);
    modport slave (input in_valid, op_a, op_b, cin, sub, out_ready,
                   output in_ready, out_valid, sum, cout, ovf, zero);
endinterface

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: valid/ready pipelined add/sub built on three-level 4-bit carry lookahead
module pipe_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input logic       clk,
    input logic       rst,
    pipe_cla_if.slave b
);
    localparam int R  = WIDTH + 3;
    localparam int RS = STAGES == 1 ? 1 : STAGES - 1;
    localparam int O  = STAGES - RS;

    if (WIDTH < 4 || WIDTH > 64 || WIDTH % 4 != 0 || STAGES < 1 || STAGES > 4) begin : g_bad
        $error("pipe_cla_adder: illegal WIDTH or STAGES");
    end

    // carries into positions 0..3 plus carry out of a 4-wide lookahead cell
    function automatic logic [4:0] la4(input logic [3:0] p, input logic [3:0] g, input logic c);
        la4 = {g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0] | &p & c,
               g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c,
               g[1] | p[1] & g[0] | p[1] & p[0] & c,
               g[0] | p[0] & c,
               c};
    endfunction

    // operands are zero-padded to 64 bits so the same three-level tree serves every width
    function automatic logic [R-1:0] calc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bb,
                                          input logic c0);
        logic [63:0] p, g, s;
        logic [15:0] gp1, gg1;
        logic [3:0]  gp2, gg2;
        logic [4:0]  c3, t;
        logic [16:0] c1;
        p = 64'(a ^ bb);
        g = 64'(a & bb);
        for (int i = 0; i < 16; i++) begin
            gp1[i] = &p[4*i +: 4];
            t = la4(p[4*i +: 4], g[4*i +: 4], 1'b0);
            gg1[i] = t[4];
        end
        for (int j = 0; j < 4; j++) begin
            gp2[j] = &gp1[4*j +: 4];
            t = la4(gp1[4*j +: 4], gg1[4*j +: 4], 1'b0);
            gg2[j] = t[4];
        end
        c3 = la4(gp2, gg2, c0);
        for (int j = 0; j < 4; j++) begin
            t = la4(gp1[4*j +: 4], gg1[4*j +: 4], c3[j]);
            c1[4*j +: 4] = t[3:0];
        end
        c1[16] = c3[4];
        for (int i = 0; i < 16; i++) begin
            t = la4(p[4*i +: 4], g[4*i +: 4], c1[i]);
            s[4*i +: 4] = p[4*i +: 4] ^ t[3:0];
        end
        calc = {s[WIDTH-1:0] == '0,
                (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]),
                c1[WIDTH/4],
                s[WIDTH-1:0]};
    endfunction

    logic [STAGES-1:0] v, ld, vin;
    logic [R-1:0]      res_in;
    logic [WIDTH-1:0]  bx;

    assign bx  = b.sub ? ~b.op_b : b.op_b;
    assign vin = STAGES'({v, b.in_valid});

    // a stage loads when it or any stage downstream of it has room, or the consumer drains
    for (genvar k = 0; k < STAGES; k++) begin : g_ld
        assign ld[k] = b.out_ready | ~&v[STAGES-1:k];
    end

    assign b.in_ready  = ld[0];
    assign b.out_valid = v[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) v <= '0;
        else     v <= (vin & ld) | (v & ~ld);
    end

    if (STAGES == 1) begin : g_comb
        assign res_in = calc(b.op_a, bx, b.sub | b.cin);
    end else begin : g_ops
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        always_ff @(posedge clk) begin
            if (rst) begin
                ra <= '0;
                rb <= '0;
                rc <= 1'b0;
            end else if (ld[0]) begin
                ra <= b.op_a;
                rb <= bx;
                rc <= b.sub | b.cin;
            end
        end
        assign res_in = calc(ra, rb, rc);
    end

    for (genvar j = 0; j < RS; j++) begin : g_rs
        logic [R-1:0] r;
        if (j == 0) begin : g_f
            always_ff @(posedge clk) begin
                if (rst)            r <= '0;
                else if (ld[j + O]) r <= res_in;
            end
        end else begin : g_n
            always_ff @(posedge clk) begin
                if (rst)            r <= '0;
                else if (ld[j + O]) r <= g_rs[j-1].r;
            end
        end
    end

    assign {b.zero, b.ovf, b.cout, b.sum} = g_rs[RS-1].r;
endmodule
